// File: rtl/sum3_pkg.sv
// Shared definitions for the three-operand sum decomposer.
//   state_e          : FSM states of the decomposer
//   MAX_OPERAND(w)   : largest operand value for a w-bit operand (2^w - 1)
//   MAX_EXACT_SUM(w) : largest exact sum of three w-bit operands (3 * (2^w - 1))
package sum3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int MAX_OPERAND(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int MAX_EXACT_SUM(input int w);
    return 3 * ((1 << w) - 1);
  endfunction

endpackage

// File: rtl/sum3_residue.sv
// Combinational residue for one (a, b) candidate: c = target - a - b.
// Ports:
//   target_i     : requested sum (WIDTH+2 bits)
//   a_i, b_i     : candidate operands
//   exact_i      : 1 = exact integer sum, 0 = modulo 2^WIDTH
//   c_o          : third operand (low WIDTH bits of the residue)
//   cand_valid_o : candidate yields a legal triple
module sum3_residue #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH+1:0] target_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             exact_i,
  output logic [WIDTH-1:0] c_o,
  output logic             cand_valid_o
);

  logic [WIDTH+1:0] cFull;

  // Residue in WIDTH+2-bit two's complement. In exact mode the target never
  // exceeds 3*(2^WIDTH-1), so the true residue lies in [-2*(2^WIDTH-1),
  // 3*(2^WIDTH-1)]; no out-of-range value in that window aliases into
  // [0, 2^WIDTH-1] modulo 2^(WIDTH+2), so testing the two top bits for zero
  // is an exact range check.
  always_comb begin
    cFull        = target_i - {2'b00, a_i} - {2'b00, b_i};
    c_o          = cFull[WIDTH-1:0];
    cand_valid_o = !exact_i || (cFull[WIDTH+1:WIDTH] == 2'b00);
  end

endmodule

// File: rtl/sum3_decomposer.sv
// Enumerates every operand triple (a, b, c) whose sum equals a target and
// streams them out over a valid/ready interface, in modulo-2^WIDTH or exact
// mode.
// Ports:
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   start_i                : begin an enumeration (sampled only in IDLE)
//   target_i, exact_i      : requested sum and mode, captured with start_i
//   out_valid_o/out_ready_i: triple handshake
//   out_a_o/out_b_o/out_c_o: presented triple
//   busy_o                 : high in SCAN and DONE
//   done_o                 : one-cycle pulse at the end of an enumeration
//   count_o                : triples accepted in the current or last run
module sum3_decomposer
  import sum3_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH+1:0]   target_i,
  input  logic               exact_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   out_a_o,
  output logic [WIDTH-1:0]   out_b_o,
  output logic [WIDTH-1:0]   out_c_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH:0]   count_o
);

  localparam int CW = 2 * WIDTH + 1;
  localparam logic [WIDTH-1:0] MaxOp  = WIDTH'(MAX_OPERAND(WIDTH));
  localparam logic [WIDTH+1:0] MaxSum = (WIDTH + 2)'(MAX_EXACT_SUM(WIDTH));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH+1:0] target_q, target_d;
  logic             exact_q, exact_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] cRes;
  logic             candValid;
  logic             advance;

  sum3_residue #(.WIDTH(WIDTH)) u_residue (
    .target_i     (target_q),
    .a_i          (a_q),
    .b_i          (b_q),
    .exact_i      (exact_q),
    .c_o          (cRes),
    .cand_valid_o (candValid)
  );

  // An invalid candidate is skipped immediately; a valid one waits for the
  // consumer, which stretches it without moving (a, b).
  assign advance = !candValid || out_ready_i;

  // Next-state logic: capture on start, walk b fastest then a, and leave
  // SCAN once the (max, max) candidate has been accepted or skipped.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    target_d = target_q;
    exact_d  = exact_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          target_d = target_i;
          exact_d  = exact_i;
          count_d  = '0;
          a_d      = '0;
          b_d      = '0;
          if (exact_i && (target_i > MaxSum)) begin
            state_d = DONE;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (advance) begin
          if (candValid) begin
            count_d = count_q + CW'(1);
          end
          if (b_q == MaxOp) begin
            b_d = '0;
            if (a_q == MaxOp) begin
              state_d = DONE;
            end else begin
              a_d = a_q + WIDTH'(1);
            end
          end else begin
            b_d = b_q + WIDTH'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any run without a done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      target_q <= '0;
      exact_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      target_q <= target_d;
      exact_q  <= exact_d;
      count_q  <= count_d;
    end
  end

  // Outputs are decoded from registered state only; out_ready_i never
  // reaches them.
  always_comb begin
    out_valid_o = (state_q == SCAN) && candValid;
    out_a_o     = a_q;
    out_b_o     = b_q;
    out_c_o     = cRes;
    busy_o      = (state_q == SCAN) || (state_q == DONE);
    done_o      = (state_q == DONE);
    count_o     = count_q;
  end

endmodule

// File: tb/tb_sum3_decomposer.sv
// Directed, table-driven bench for sum3_decomposer.
module tb_sum3_decomposer;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W+1:0]   target;
  logic           exact;
  logic           outReady;
  logic           outValid;
  logic [W-1:0]   outA, outB, outC;
  logic           busy, done;
  logic [2*W:0]   count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       exact;
    logic [W+1:0] target;
    int         expCount;
    int         expFirstCyc;
    int         expDoneCyc;
    int         fa, fb, fc;
    int         la, lb, lc;
  } vec_t;

  vec_t vecs[8];

  sum3_decomposer #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .target_i    (target),
    .exact_i     (exact),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .out_a_o     (outA),
    .out_b_o     (outB),
    .out_c_o     (outC),
    .busy_o      (busy),
    .done_o      (done),
    .count_o     (count)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  // Single comparison point; every check funnels through here
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Starts one run and follows it to its done pulse, checking triples,
  // ordering, hold behaviour, first/last triples, count and timing
  task automatic applyStimulus(input vec_t v, input bit bp, input int pulseAt,
                               input string tag);
    int cyc, hs, doneCyc, firstCyc, sumErrs, orderErrs, holdErrs, key, lastKey;
    int fTrip, lTrip, s;
    bit stalled;
    logic [W-1:0] pa, pb, pc;
    cyc = 1; hs = 0; doneCyc = 0; firstCyc = 0; sumErrs = 0; orderErrs = 0;
    holdErrs = 0; lastKey = -1; fTrip = -1; lTrip = -1; stalled = 1'b0;
    pa = '0; pb = '0; pc = '0;
    @(negedge clk);
    target = v.target;
    exact  = v.exact;
    start  = 1'b1;
    outReady = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc <= 2000 && doneCyc == 0) begin
      @(negedge clk);
      if (bp) outReady = 1'($urandom_range(0, 1));
      if (cyc == 1) checkOutput({tag, " busy@1"}, 32'(busy), 32'd1);
      if (done) begin
        doneCyc = cyc;
      end else begin
        if (stalled && (!outValid || outA != pa || outB != pb || outC != pc))
          holdErrs++;
        if (outValid) begin
          if (outReady) begin
            hs++;
            if (hs == 1) begin
              firstCyc = cyc;
              fTrip = int'(outA) * 256 + int'(outB) * 16 + int'(outC);
            end
            lTrip = int'(outA) * 256 + int'(outB) * 16 + int'(outC);
            s = int'(outA) + int'(outB) + int'(outC);
            if (v.exact ? (s != int'(v.target)) : ((s % 16) != (int'(v.target) % 16)))
              sumErrs++;
            key = int'(outA) * 16 + int'(outB);
            if (key <= lastKey) orderErrs++;
            lastKey = key;
          end
          stalled = !outReady;
          pa = outA; pb = outB; pc = outC;
        end else begin
          stalled = 1'b0;
        end
      end
      if (pulseAt != 0 && cyc == pulseAt) begin
        start = 1'b1; target = 6'd1; exact = 1'b1;
      end
      if (pulseAt != 0 && cyc == pulseAt + 1) start = 1'b0;
      if (doneCyc == 0) begin
        @(posedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    outReady = 1'b1;
    checkOutput({tag, " done seen"}, 32'(doneCyc != 0), 32'd1);
    checkOutput({tag, " handshakes"}, 32'(hs), 32'(v.expCount));
    checkOutput({tag, " count_o"}, 32'(count), 32'(v.expCount));
    checkOutput({tag, " sum errors"}, 32'(sumErrs), 32'd0);
    checkOutput({tag, " order errors"}, 32'(orderErrs), 32'd0);
    checkOutput({tag, " hold errors"}, 32'(holdErrs), 32'd0);
    if (v.expDoneCyc != 0)
      checkOutput({tag, " done cycle"}, 32'(doneCyc), 32'(v.expDoneCyc));
    if (v.expFirstCyc != 0)
      checkOutput({tag, " first cycle"}, 32'(firstCyc), 32'(v.expFirstCyc));
    if (v.expCount > 0) begin
      checkOutput({tag, " first triple"}, 32'(fTrip), 32'(v.fa * 256 + v.fb * 16 + v.fc));
      checkOutput({tag, " last triple"}, 32'(lTrip), 32'(v.la * 256 + v.lb * 16 + v.lc));
    end
    @(negedge clk);
    checkOutput({tag, " done after pulse"}, 32'(done), 32'd0);
    checkOutput({tag, " busy after done"}, 32'(busy), 32'd0);
    checkOutput({tag, " count held"}, 32'(count), 32'(v.expCount));
  endtask

  // Directed sequence: reset, table of runs, backpressure, reset mid-run,
  // start pulsed during SCAN
  initial begin
    vec_t bpVec;
    int hs, doneSeen;
    rst = 1'b1; start = 1'b0; target = '0; exact = 1'b0; outReady = 1'b1;

    vecs[0] = '{1'b0, 6'd5,  256, 1,   257, 0, 0, 5,   15, 15, 7};
    vecs[1] = '{1'b1, 6'd15, 136, 1,   257, 0, 0, 15,  15, 0, 0};
    vecs[2] = '{1'b1, 6'd0,  1,   1,   257, 0, 0, 0,   0, 0, 0};
    vecs[3] = '{1'b1, 6'd45, 1,   256, 257, 15, 15, 15, 15, 15, 15};
    vecs[4] = '{1'b1, 6'd46, 0,   0,   1,   0, 0, 0,   0, 0, 0};
    vecs[5] = '{1'b1, 6'd30, 136, 16,  257, 0, 15, 15, 15, 15, 0};
    vecs[6] = '{1'b0, 6'd37, 256, 1,   257, 0, 0, 5,   15, 15, 7};
    vecs[7] = '{1'b1, 6'd63, 0,   0,   1,   0, 0, 0,   0, 0, 0};

    #12;
    checkOutput("reset out_valid", 32'(outValid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset count", 32'(count), 32'd0);
    checkOutput("reset triple", {20'd0, outA, outB, outC}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], 1'b0, 0, $sformatf("vec%0d", i));
    end

    bpVec = '{1'b1, 6'd16, 150, 0, 0, 0, 1, 15, 15, 1, 0};
    applyStimulus(bpVec, 1'b1, 0, "backpressure t16");

    // Reset after ten handshakes
    @(negedge clk);
    target = 6'd3; exact = 1'b0; start = 1'b1; outReady = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hs = 0;
    for (int c = 0; c < 100 && hs < 10; c++) begin
      @(negedge clk);
      if (outValid && outReady) hs++;
    end
    checkOutput("ten handshakes reached", 32'(hs), 32'd10);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid-run reset out_valid", 32'(outValid), 32'd0);
    checkOutput("mid-run reset count", 32'(count), 32'd0);
    checkOutput("mid-run reset busy", 32'(busy), 32'd0);
    doneSeen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("no done after reset", 32'(doneSeen), 32'd0);
    applyStimulus('{1'b0, 6'd3, 256, 1, 257, 0, 0, 3, 15, 15, 5}, 1'b0, 0,
                  "restart after reset");

    // start pulsed mid-scan with a different target/mode must be ignored
    applyStimulus(vecs[0], 1'b0, 50, "start during scan");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
